// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operand path; also consumed by the control decoder.
package alu_pkg;

    localparam logic [1:0] BSEL_REG   = 2'b00;
    localparam logic [1:0] BSEL_SEXT  = 2'b01;
    localparam logic [1:0] BSEL_ZEXT  = 2'b10;
    localparam logic [1:0] BSEL_UPPER = 2'b11;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Operand request / operand pair handshake between register read, the operand stage and the ALU.
interface alu_operand_stage_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned REG_AW = 3
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rs_q;
    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs_addr;
    logic [IMM_W-1:0]  offset;
    logic [1:0]        b_sel;
    logic              fwd_en;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    // Stage-side view.
    modport slave (
        input  in_valid, rd_q, rs_q, rd_addr, rs_addr, offset, b_sel,
        input  fwd_en, fwd_addr, fwd_data, out_ready,
        output in_ready, out_valid, op_a, op_b
    );

    // Environment-side view (register read + ALU).
    modport master (
        output in_valid, rd_q, rs_q, rd_addr, rs_addr, offset, b_sel,
        output fwd_en, fwd_addr, fwd_data, out_ready,
        input  in_ready, out_valid, op_a, op_b
    );

endinterface

// File: rtl/operand_extend.sv
// Widens the instruction immediate to operand width according to the b_sel mode.
module operand_extend
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8
) (
    input  logic [IMM_W-1:0]  offset_i,
    input  logic [1:0]        b_sel_i,
    output logic [DATA_W-1:0] imm_o
);

    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] zext;
    logic [DATA_W-1:0] upper;

    // Full-width immediates need no padding, so every mode collapses to the raw offset.
    if (IMM_W < DATA_W) begin : g_pad
        assign sext  = {{(DATA_W - IMM_W){offset_i[IMM_W-1]}}, offset_i};
        assign zext  = {{(DATA_W - IMM_W){1'b0}}, offset_i};
        assign upper = {offset_i, {(DATA_W - IMM_W){1'b0}}};
    end else begin : g_full
        assign sext  = offset_i;
        assign zext  = offset_i;
        assign upper = offset_i;
    end

    always_comb begin
        imm_o = '0;
        unique case (b_sel_i)
            BSEL_SEXT:  imm_o = sext;
            BSEL_ZEXT:  imm_o = zext;
            BSEL_UPPER: imm_o = upper;
            default:    imm_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand formation with write-back bypass, registered output and a one-entry skid buffer.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IMM_W  = 8,
    parameter int unsigned REG_AW = 3
) (
    input  logic                clk,
    input  logic                rst,
    alu_operand_stage_if.slave  bus
);

    logic [REG_AW-1:0] rd_addr;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] fwd_addr;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] a_src;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] pair_b;
    logic              accept;
    logic              load_out;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_a_q, skid_a_d;
    logic [DATA_W-1:0] skid_b_q, skid_b_d;

    assign rd_addr  = bus.rd_addr;
    assign rs_addr  = bus.rs_addr;
    assign fwd_addr = bus.fwd_addr;

    operand_extend #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_extend (
        .offset_i (bus.offset),
        .b_sel_i  (bus.b_sel),
        .imm_o    (imm)
    );

    // Bypass is evaluated only against the accept-cycle write-back.
    assign a_src  = (bus.fwd_en && (fwd_addr == rd_addr)) ? bus.fwd_data : bus.rd_q;
    assign b_reg  = (bus.fwd_en && (fwd_addr == rs_addr)) ? bus.fwd_data : bus.rs_q;
    assign pair_b = (bus.b_sel == BSEL_REG) ? b_reg : imm;

    assign bus.in_ready = !rst && !skid_valid_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign load_out     = !out_valid_q || bus.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        if (load_out) begin
            // The skid entry is older than any new request, so it drains first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                op_a_d       = skid_a_q;
                op_b_d       = skid_b_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                op_a_d      = a_src;
                op_b_d      = pair_b;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_a_d     = a_src;
            skid_b_d     = pair_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;

endmodule
